// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - tick-sampled push-button debouncer with press, release and long-press events
module button_debouncer #(
   parameter int STABLE_TICKS = 20,
   parameter int LONG_TICKS   = 1000,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic btn_in,
   input  logic tick_enable,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_long
);

   localparam int STAB_W = $clog2(STABLE_TICKS + 1);
   localparam int HOLD_W = $clog2(LONG_TICKS + 1);

   // Last pending count before a new level is accepted on the next agreeing sample.
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

   // Pin level that means "not pressed".
   localparam logic REL_LVL = (ACTIVE_LOW != 0);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_PEND,
      PRESSED,
      RELEASE_PEND
   } state_t;

   state_t            state;
   logic [1:0]        sync_q;
   logic [STAB_W-1:0] stab_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              pressed;
   logic              hold_sat;
   logic              long_hit;

   // Normalised sample: 1 means the button is pressed regardless of pin polarity.
   assign pressed  = sync_q[1] ^ REL_LVL;
   // hold_cnt stops at LONG_TICKS so the long-press pulse cannot repeat during one press.
   assign hold_sat = (hold_cnt == HOLD_MAX);
   assign long_hit = (hold_cnt == HOLD_LAST);

   // Two-flop synchronizer for the asynchronous pin; resets to the released level.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync_q <= {2{REL_LVL}};
      end else begin
         sync_q <= {sync_q[0], btn_in};
      end
   end

   // Debounce FSM with registered outputs; advances only on tick strobes.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state       <= RELEASED;
         stab_cnt    <= '0;
         hold_cnt    <= '0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         btn_long    <= 1'b0;
      end else begin
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         btn_long    <= 1'b0;
         if (tick_enable) begin
            case (state)
               RELEASED: begin
                  if (pressed) begin
                     if (STABLE_TICKS == 1) begin
                        state     <= PRESSED;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                     end else begin
                        state    <= PRESS_PEND;
                        stab_cnt <= STAB_W'(1);
                     end
                  end
               end
               PRESS_PEND: begin
                  if (pressed) begin
                     if (stab_cnt == STAB_LAST) begin
                        state     <= PRESSED;
                        stab_cnt  <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                     end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                     end
                  end else begin
                     state    <= RELEASED;
                     stab_cnt <= '0;
                  end
               end
               PRESSED: begin
                  if (pressed) begin
                     if (!hold_sat) begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                     btn_long <= long_hit;
                  end else if (STABLE_TICKS == 1) begin
                     state       <= RELEASED;
                     hold_cnt    <= '0;
                     btn_level   <= 1'b0;
                     btn_release <= 1'b1;
                  end else begin
                     state    <= RELEASE_PEND;
                     stab_cnt <= STAB_W'(1);
                  end
               end
               RELEASE_PEND: begin
                  if (!pressed) begin
                     if (stab_cnt == STAB_LAST) begin
                        state       <= RELEASED;
                        stab_cnt    <= '0;
                        hold_cnt    <= '0;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                     end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                     end
                  end else begin
                     // A pressed sample ends the pending release; it counts as held time.
                     state    <= PRESSED;
                     stab_cnt <= '0;
                     if (!hold_sat) begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                     btn_long <= long_hit;
                  end
               end
               default: begin
                  state    <= RELEASED;
                  stab_cnt <= '0;
                  hold_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer
module tb_button_debouncer;

   localparam int ST = 4;
   localparam int LT = 10;

   logic sys_clk     = 1'b0;
   logic sys_rst     = 1'b1;
   logic btn_in      = 1'b1;
   logic tick_enable = 1'b0;
   logic btn_level;
   logic btn_press;
   logic btn_release;
   logic btn_long;

   button_debouncer #(
      .STABLE_TICKS(ST),
      .LONG_TICKS  (LT),
      .ACTIVE_LOW  (1)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .btn_in     (btn_in),
      .tick_enable(tick_enable),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .btn_long   (btn_long)
   );

   always #5 sys_clk = ~sys_clk;

   // Scoreboard: expected {level, press, release, long} after each clock edge.
   logic [3:0] exp_q[$];
   int vectors     = 0;
   int miscompares = 0;
   int n_press     = 0;
   int n_release   = 0;
   int n_long      = 0;
   int cyc         = 0;
   int tick_mode   = 0;

   // Reference model: accepted level, run of disagreeing tick samples, held ticks.
   logic pin_hist[$] = '{1'b1, 1'b1};
   bit   m_level = 1'b0;
   int   m_run   = 0;
   int   m_hold  = 0;

   task automatic model_edge();
      logic raw;
      bit   p;
      bit   old_level;
      logic pr;
      logic rl;
      logic lg;
      pr = 1'b0;
      rl = 1'b0;
      lg = 1'b0;
      if (sys_rst) begin
         pin_hist = '{1'b1, 1'b1};
         m_level  = 1'b0;
         m_run    = 0;
         m_hold   = 0;
      end else begin
         raw = pin_hist.pop_front();
         pin_hist.push_back(btn_in);
         if (tick_enable) begin
            p         = !raw;
            old_level = m_level;
            if (p == m_level) begin
               m_run = 0;
            end else begin
               m_run++;
               if (m_run == ST) begin
                  m_level = p;
                  m_run   = 0;
                  if (p) pr = 1'b1;
                  else begin
                     rl     = 1'b1;
                     m_hold = 0;
                  end
               end
            end
            if (old_level && p && m_hold < LT) begin
               m_hold++;
               if (m_hold == LT) lg = 1'b1;
            end
         end
      end
      exp_q.push_back({m_level, pr, rl, lg});
   endtask

   task automatic step(input logic b, input logic r);
      @(negedge sys_clk);
      btn_in  = b;
      sys_rst = r;
      case (tick_mode)
         0:       tick_enable = (cyc % 4 == 0);
         1:       tick_enable = ($urandom_range(0, 2) == 0);
         default: tick_enable = 1'b1;
      endcase
      cyc++;
      @(posedge sys_clk);
      model_edge();
   endtask

   // One tick period at level v; optional single-cycle low glitch away from the sampled cycle.
   task automatic slot(input logic v, input bit glitch);
      for (int k = 0; k < 4; k++) begin
         if (glitch && (cyc % 4 == 0)) step(1'b0, 1'b0);
         else step(v, 1'b0);
      end
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clr();
      n_press   = 0;
      n_release = 0;
      n_long    = 0;
   endtask

   task automatic chk(input string name, input int got, input int expv);
      vectors++;
      if (got != expv) begin
         miscompares++;
         $display("FAIL %s got=%0d expected=%0d", name, got, expv);
      end
   endtask

   task automatic rand_phase(input int n);
      int  i;
      int  len;
      bit  v;
      logic b;
      logic r;
      i = 0;
      while (i < n) begin
         v   = $urandom_range(0, 1);
         len = $urandom_range(1, 60);
         for (int j = 0; j < len && i < n; j++) begin
            b = v;
            r = 1'b0;
            if ($urandom_range(0, 9) == 0) b = !v;
            if ($urandom_range(0, 399) == 0) r = 1'b1;
            step(b, r);
            i++;
         end
      end
   endtask

   // Monitor: compares DUT outputs against the scoreboard one step after each edge.
   initial begin
      logic [3:0] got;
      logic [3:0] expv;
      forever begin
         @(posedge sys_clk);
         #1;
         if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            got  = {btn_level, btn_press, btn_release, btn_long};
            vectors++;
            if (got !== expv) begin
               miscompares++;
               $display("FAIL outputs cyc=%0d got lvl/prs/rel/lng=%b expected=%b", cyc, got, expv);
            end
            n_press   += int'(btn_press);
            n_release += int'(btn_release);
            n_long    += int'(btn_long);
         end
      end
   end

   initial begin
      // T1: reset then 50 idle ticks
      for (int k = 0; k < 8; k++) step(1'b1, 1'b1);
      settle();
      chk("t1_reset_level", int'(btn_level), 0);
      clr();
      for (int k = 0; k < 50; k++) slot(1'b1, 1'b0);
      settle();
      chk("t1_idle_pulses", n_press + n_release + n_long, 0);
      clr();

      // T2: clean press
      for (int k = 0; k < 7; k++) slot(1'b0, 1'b0);
      settle();
      chk("t2_press_count", n_press, 1);
      chk("t2_level", int'(btn_level), 1);
      clr();

      // T4: keep holding; long pulse exactly once
      for (int k = 0; k < 34; k++) slot(1'b0, 1'b0);
      settle();
      chk("t4_long_count", n_long, 1);
      chk("t4_no_release", n_release, 0);
      clr();

      // T5: release with glitches between ticks
      for (int k = 0; k < 7; k++) slot(1'b1, 1'b1);
      settle();
      chk("t5_release_count", n_release, 1);
      chk("t5_level", int'(btn_level), 0);
      chk("t5_no_press", n_press + n_long, 0);
      clr();

      // T3: bounce 3 low, 1 high, then sustained low
      for (int k = 0; k < 3; k++) slot(1'b0, 1'b0);
      slot(1'b1, 1'b0);
      settle();
      chk("t3_no_early_press", n_press, 0);
      for (int k = 0; k < 7; k++) slot(1'b0, 1'b0);
      settle();
      chk("t3_press_count", n_press, 1);
      clr();

      // T6: reset while pressed, button still held
      slot(1'b0, 1'b0);
      step(1'b0, 1'b1);
      settle();
      chk("t6_level_after_reset", int'(btn_level), 0);
      step(1'b0, 1'b1);
      settle();
      chk("t6_no_release", n_release, 0);
      clr();
      for (int k = 0; k < 7; k++) slot(1'b0, 1'b0);
      settle();
      chk("t6_repress_count", n_press, 1);
      chk("t6_repress_release", n_release, 0);
      clr();

      // Randomized: sparse random ticks, then tick_enable stuck high
      tick_mode = 1;
      rand_phase(2500);
      tick_mode = 2;
      rand_phase(600);
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
